// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared raster timing for the scan compositor. It holds the default
// 800x600@72Hz timing, the derived line/frame totals and the sync-window
// bounds, plus the 12-bit colour type used on the pixel path.
// There are no ports. Optional feature macro used by importers: VGA_BORDER_EN.
// ---------------------------------------------------------------------------
package vga_timing_pkg;

   localparam int unsigned CNT_W = 11;

   // Helpers keep the derived values consistent when a module overrides timing
   function automatic int unsigned line_total(input int unsigned vis, input int unsigned front,
                                              input int unsigned sync, input int unsigned back);
      return vis + front + sync + back;
   endfunction

   function automatic int unsigned sync_start(input int unsigned vis, input int unsigned front);
      return vis + front;
   endfunction

   function automatic int unsigned sync_end(input int unsigned vis, input int unsigned front,
                                            input int unsigned sync);
      return vis + front + sync - 1;
   endfunction

   localparam int unsigned DEF_H_VISIBLE = 800;
   localparam int unsigned DEF_H_FRONT   = 56;
   localparam int unsigned DEF_H_SYNC    = 120;
   localparam int unsigned DEF_H_BACK    = 64;
   localparam int unsigned DEF_V_VISIBLE = 600;
   localparam int unsigned DEF_V_FRONT   = 37;
   localparam int unsigned DEF_V_SYNC    = 6;
   localparam int unsigned DEF_V_BACK    = 23;

   localparam int unsigned H_TOTAL = line_total(DEF_H_VISIBLE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
   localparam int unsigned V_TOTAL = line_total(DEF_V_VISIBLE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);

   localparam int unsigned H_SYNC_START = sync_start(DEF_H_VISIBLE, DEF_H_FRONT);
   localparam int unsigned H_SYNC_END   = sync_end(DEF_H_VISIBLE, DEF_H_FRONT, DEF_H_SYNC);
   localparam int unsigned V_SYNC_START = sync_start(DEF_V_VISIBLE, DEF_V_FRONT);
   localparam int unsigned V_SYNC_END   = sync_end(DEF_V_VISIBLE, DEF_V_FRONT, DEF_V_SYNC);

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb12_t;

endpackage

// File: rtl/vga_sync_counter.sv
// ---------------------------------------------------------------------------
// vga_sync_counter
// Raster position counters plus the combinational timing flags derived from
// them.
//   clk           pixel clock
//   reset         asynchronous, active-low
//   o_hCount      horizontal position, 0..H_TOTAL-1
//   o_vCount      vertical position, 0..V_TOTAL-1 (advances on line wrap)
//   o_visible     position lies in the visible window
//   o_hSyncRaw    position lies in the horizontal sync window (active high)
//   o_vSyncRaw    position lies in the vertical sync window (active high)
//   o_frameTick   one-clock pulse at the start of vertical blank
// ---------------------------------------------------------------------------
module vga_sync_counter
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
   parameter int unsigned H_FRONT   = DEF_H_FRONT,
   parameter int unsigned H_SYNC    = DEF_H_SYNC,
   parameter int unsigned H_BACK    = DEF_H_BACK,
   parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
   parameter int unsigned V_FRONT   = DEF_V_FRONT,
   parameter int unsigned V_SYNC    = DEF_V_SYNC,
   parameter int unsigned V_BACK    = DEF_V_BACK
)(
   input  logic             clk,
   input  logic             reset,
   output logic [CNT_W-1:0] o_hCount,
   output logic [CNT_W-1:0] o_vCount,
   output logic             o_visible,
   output logic             o_hSyncRaw,
   output logic             o_vSyncRaw,
   output logic             o_frameTick
);

   localparam logic [CNT_W-1:0] C_H_LAST = CNT_W'(line_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK) - 1);
   localparam logic [CNT_W-1:0] C_V_LAST = CNT_W'(line_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK) - 1);
   localparam logic [CNT_W-1:0] C_H_VIS  = CNT_W'(H_VISIBLE);
   localparam logic [CNT_W-1:0] C_V_VIS  = CNT_W'(V_VISIBLE);
   localparam logic [CNT_W-1:0] C_HS_BEG = CNT_W'(sync_start(H_VISIBLE, H_FRONT));
   localparam logic [CNT_W-1:0] C_HS_END = CNT_W'(sync_end(H_VISIBLE, H_FRONT, H_SYNC));
   localparam logic [CNT_W-1:0] C_VS_BEG = CNT_W'(sync_start(V_VISIBLE, V_FRONT));
   localparam logic [CNT_W-1:0] C_VS_END = CNT_W'(sync_end(V_VISIBLE, V_FRONT, V_SYNC));

   logic [CNT_W-1:0] r_hCount;
   logic [CNT_W-1:0] r_vCount;
   logic             w_hWrap;
   logic             w_vWrap;

   assign w_hWrap = (r_hCount == C_H_LAST);
   assign w_vWrap = (r_vCount == C_V_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_hCount <= '0;
         r_vCount <= '0;
      end else if (w_hWrap) begin
         r_hCount <= '0;
         r_vCount <= w_vWrap ? '0 : r_vCount + CNT_W'(1);
      end else begin
         r_hCount <= r_hCount + CNT_W'(1);
      end
   end

   assign o_hCount   = r_hCount;
   assign o_vCount   = r_vCount;
   assign o_visible  = (r_hCount < C_H_VIS) && (r_vCount < C_V_VIS);
   assign o_hSyncRaw = (r_hCount >= C_HS_BEG) && (r_hCount <= C_HS_END);
   assign o_vSyncRaw = (r_vCount >= C_VS_BEG) && (r_vCount <= C_VS_END);

   // Gated by reset so the widget enable can never fire while held in reset
   assign o_frameTick = reset && (r_hCount == '0) && (r_vCount == C_V_VIS);

endmodule

// File: rtl/vga_scan_compositor.sv
// ---------------------------------------------------------------------------
// vga_scan_compositor
// Raster generator and widget compositor. Publishes the live scan position to
// the widgets, resolves their yes flags by lowest-lane priority over the
// background, and registers colour, sync and blank for the DAC pins, one
// clock behind X/Y.
//   clk, reset                 pixel clock; asynchronous active-low reset
//   X, Y                       current scan position (unregistered)
//   frameTick                  one-clock pulse per frame (widget enable)
//   widgetYes[N_WIDGETS]       per-lane hit flags for current X/Y
//   widgetRGB[12*N_WIDGETS]    per-lane {r,g,b}, lane i at [12i+11:12i]
//   bgRed/bgGreen/bgBlue       background colour
//   red/green/blue             registered pixel colour
//   hSync, vSync, blank        registered timing outputs
// Optional feature: define VGA_BORDER_EN to force a white 1-pixel frame
// around the visible area, above all widgets and the background.
// ---------------------------------------------------------------------------
module vga_scan_compositor
   import vga_timing_pkg::*;
#(
   parameter int unsigned N_WIDGETS = 4,
   parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
   parameter int unsigned H_FRONT   = DEF_H_FRONT,
   parameter int unsigned H_SYNC    = DEF_H_SYNC,
   parameter int unsigned H_BACK    = DEF_H_BACK,
   parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
   parameter int unsigned V_FRONT   = DEF_V_FRONT,
   parameter int unsigned V_SYNC    = DEF_V_SYNC,
   parameter int unsigned V_BACK    = DEF_V_BACK,
   parameter int unsigned SYNC_POL  = 1
)(
   input  logic                    clk,
   input  logic                    reset,
   output logic [CNT_W-1:0]        X,
   output logic [CNT_W-1:0]        Y,
   output logic                    frameTick,
   input  logic [N_WIDGETS-1:0]    widgetYes,
   input  logic [12*N_WIDGETS-1:0] widgetRGB,
   input  logic [3:0]              bgRed,
   input  logic [3:0]              bgGreen,
   input  logic [3:0]              bgBlue,
   output logic [3:0]              red,
   output logic [3:0]              green,
   output logic [3:0]              blue,
   output logic                    hSync,
   output logic                    vSync,
   output logic                    blank
);

   localparam logic C_ACT = (SYNC_POL != 0);

   logic [CNT_W-1:0] w_hCount;
   logic [CNT_W-1:0] w_vCount;
   logic             w_visible;
   logic             w_hSyncRaw;
   logic             w_vSyncRaw;
   logic             w_hit;
   rgb12_t           w_pix;

   rgb12_t           r_pix;
   logic             r_hSync;
   logic             r_vSync;
   logic             r_blank;

   vga_sync_counter #(
      .H_VISIBLE (H_VISIBLE),
      .H_FRONT   (H_FRONT),
      .H_SYNC    (H_SYNC),
      .H_BACK    (H_BACK),
      .V_VISIBLE (V_VISIBLE),
      .V_FRONT   (V_FRONT),
      .V_SYNC    (V_SYNC),
      .V_BACK    (V_BACK)
   ) u_sync_counter (
      .clk         (clk),
      .reset       (reset),
      .o_hCount    (w_hCount),
      .o_vCount    (w_vCount),
      .o_visible   (w_visible),
      .o_hSyncRaw  (w_hSyncRaw),
      .o_vSyncRaw  (w_vSyncRaw),
      .o_frameTick (frameTick)
   );

   assign X = w_hCount;
   assign Y = w_vCount;

`ifdef VGA_BORDER_EN
   localparam logic [CNT_W-1:0] C_H_EDGE = CNT_W'(H_VISIBLE - 1);
   localparam logic [CNT_W-1:0] C_V_EDGE = CNT_W'(V_VISIBLE - 1);

   logic w_border;
   assign w_border = (w_hCount == '0) || (w_hCount == C_H_EDGE) ||
                     (w_vCount == '0) || (w_vCount == C_V_EDGE);
`endif

   // Lowest lane wins: once a hit is latched in w_hit, higher lanes are ignored
   always_comb begin
      w_pix = {bgRed, bgGreen, bgBlue};
      w_hit = 1'b0;
      for (int unsigned i = 0; i < N_WIDGETS; i++) begin
         if (widgetYes[i] && !w_hit) begin
            w_pix = widgetRGB[12*i +: 12];
            w_hit = 1'b1;
         end
      end
`ifdef VGA_BORDER_EN
      if (w_border) begin
         w_pix = 12'hFFF;
      end
`endif
      if (!w_visible) begin
         w_pix = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pix   <= '0;
         r_blank <= 1'b1;
         r_hSync <= !C_ACT;
         r_vSync <= !C_ACT;
      end else begin
         r_pix   <= w_pix;
         r_blank <= !w_visible;
         r_hSync <= w_hSyncRaw ? C_ACT : !C_ACT;
         r_vSync <= w_vSyncRaw ? C_ACT : !C_ACT;
      end
   end

   assign red   = r_pix.r;
   assign green = r_pix.g;
   assign blue  = r_pix.b;
   assign hSync = r_hSync;
   assign vSync = r_vSync;
   assign blank = r_blank;

endmodule

// File: doc/vga_scan_compositor.md
Name: vga_scan_compositor

Overview:
Drives the raster side of the widget interface. Generates the 800x600@72Hz scan position (X, Y) and the sync and blank outputs, and raises a once-per-frame enable tick for the widgets. It gathers each widget's yes flag and RGB, resolves priority and registers the final pixel colour for the DAC pins. It sits between the widget layer and the VGA connector and runs on the 50 MHz pixel clock.

Parameters:
N_WIDGETS, 4, number of widget yes/RGB input lanes (1..8)
H_VISIBLE, 800, visible pixels per line
H_FRONT, 56, horizontal front porch in clocks
H_SYNC, 120, horizontal sync width in clocks
H_BACK, 64, horizontal back porch in clocks
V_VISIBLE, 600, visible lines per frame
V_FRONT, 37, vertical front porch in lines
V_SYNC, 6, vertical sync width in lines
V_BACK, 23, vertical back porch in lines
SYNC_POL, 1, active level of hSync/vSync (1 = positive)

Ports:
clk  in  1  pixel clock, 50 MHz
reset  in  1  asynchronous, active-low reset
X  out  11  current horizontal count, 0..1039
Y  out  11  current vertical count, 0..665
frameTick  out  1  one-cycle pulse per frame; drives widget enable
widgetYes  in  N_WIDGETS  per-widget "pixel inside me" flags for the current X/Y
widgetRGB  in  12*N_WIDGETS  per-widget {red,green,blue}, 4 bits each; lane i occupies [12i+11:12i]
bgRed, bgGreen, bgBlue  in  4 each  background colour
red, green, blue  out  4 each  registered pixel colour
hSync, vSync  out  1 each  registered sync outputs
blank  out  1  registered; high outside the visible area

Behaviour:
- Counters: hCount counts 0..H_TOTAL-1 (H_TOTAL = 1040) and wraps to 0. vCount advances only when hCount wraps. vCount counts 0..V_TOTAL-1 (V_TOTAL = 666) and wraps to 0.
- X and Y are driven directly from the counter registers, with no added delay. Widgets answer combinationally in the same cycle.
- visible = (hCount < H_VISIBLE) && (vCount < V_VISIBLE).
- Stage-1 register, so every output appears 1 clock after its X/Y:
  - blank <= !visible.
  - hSync <= SYNC_POL when 856 <= hCount <= 975, otherwise !SYNC_POL.
  - vSync <= SYNC_POL when 637 <= vCount <= 642, otherwise !SYNC_POL.
  - rgb <= 0 when !visible.
  - Otherwise rgb <= the RGB of the lowest-index lane i with widgetYes[i]=1.
  - Otherwise rgb <= {bgRed, bgGreen, bgBlue}.
- frameTick is combinational from the counters: high for exactly one clock, when hCount==0 && vCount==V_VISIBLE (start of vertical blank). Widgets therefore move once per frame, out of view.
- Reset asserted (reset=0), at any point including mid-line:
  - hCount=0, vCount=0, so X=Y=0.
  - red/green/blue = 0, blank = 1.
  - hSync and vSync at the inactive level !SYNC_POL.
  - frameTick = 0 while reset is low.
- After reset is released, the first edge advances hCount to 1.
- All counter compares are unsigned 11-bit. No widget input can stall or alter timing.
- N_WIDGETS=1 degenerates to a single lane plus background.

Optional Feature:
VGA_BORDER_EN
- Defined: pixels with visible && (hCount==0 || hCount==H_VISIBLE-1 || vCount==0 || vCount==V_VISIBLE-1) output 0xFFF. The border takes priority over all widgets and the background.
- Undefined: no border logic is generated; the border pixels follow normal priority.

Decomposition:
- Package vga_timing_pkg holds:
  - H_TOTAL, V_TOTAL, and the sync start/end constants derived from the timing parameters.
  - The rgb12_t typedef {r,g,b}.
- Sub-module vga_sync_counter owns hCount/vCount, visible, the raw hSync/vSync and frameTick.
- The top level holds the priority mux and the stage-1 output register.

Test Plan:
1. Reset low for 5 clocks, then high: X=0,Y=0 during reset. X=1039 on clock 1039 after release and X=0,Y=1 on the next clock. Y wraps 665 -> 0 after 692640 clocks.
2. Free run one line: hSync at SYNC_POL for exactly 120 consecutive clocks, first seen the cycle after X=856. vSync active for 6 lines, covering Y=637..642 plus 1 clock delay.
3. Free run 3 frames: exactly one frameTick per 692640 clocks, each at X=0,Y=600. No tick is seen while reset=0.
4. N_WIDGETS=4, X=100,Y=100, widgetYes=4'b0110, lane1=0x0F0, lane2=0xF00: next cycle rgb=0x0F0. With widgetYes=0 and bg=0x123: rgb=0x123.
5. widgetYes=4'b1111 at X=900,Y=50 -> next cycle rgb=0x000, blank=1. At X=50,Y=620 -> rgb=0x000, blank=1.
6. Reset pulled low at X=500,Y=300 -> immediately rgb=0, blank=1, hSync=vSync=!SYNC_POL, X=Y=0. With VGA_BORDER_EN defined: X=0,Y=10 with widgetYes=1 -> rgb=0xFFF.
